// File: rtl/balanca_pkg.sv
// ---------------------------------------------------------------------------
// balanca_pkg
//   Shared definitions for the weighing datapath of the digital scale.
//   - W             : width of weight samples, tare and net result
//   - peso_t        : unsigned weight word
//   - tara_op_t     : tare register operation decoded from tarar/zerar
//   - liquido_t     : net-weight result (clamped value + negative flag)
//   - calc_liquido  : gross minus tare with clamping at zero
//   - dif_abs       : absolute difference of two weights
// ---------------------------------------------------------------------------
package balanca_pkg;

    localparam int W = 16;

    typedef logic [W-1:0] peso_t;

    // Overload threshold on the raw gross sample (strictly greater overloads).
    localparam peso_t MAX_PESO_DEF   = 16'hFFF0;
    // Stability detector defaults.
    localparam int    STABLE_CYC_DEF = 8;
    localparam int    STABLE_TOL_DEF = 2;

    // Operation applied to the tare register at a clock edge.
    typedef enum logic [1:0] {
        TARA_MANTER   = 2'b00,  // keep current tare
        TARA_CAPTURAR = 2'b01,  // load tare from current gross sample
        TARA_ZERAR    = 2'b10   // clear tare
    } tara_op_t;

    typedef struct packed {
        peso_t valor;     // net weight, never wraps below zero
        logic  negativo;  // gross was below tare
    } liquido_t;

    // Gross minus tare computed one bit wider so the borrow is visible;
    // a borrow means the gross is below the tare and the result clamps to 0.
    function automatic liquido_t calc_liquido(input peso_t bruto, input peso_t tara);
        logic [W:0] dif;
        liquido_t   res;
        dif = {1'b0, bruto} - {1'b0, tara};
        if (dif[W]) begin
            res.valor    = '0;
            res.negativo = 1'b1;
        end else begin
            res.valor    = dif[W-1:0];
            res.negativo = 1'b0;
        end
        return res;
    endfunction

    function automatic peso_t dif_abs(input peso_t a, input peso_t b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage : balanca_pkg

// File: rtl/peso_sem_tara_detector_estavel.sv
// ---------------------------------------------------------------------------
// detector_estavel
//   Flags a weight reading as stable once consecutive samples have stayed
//   within a small tolerance of each other for a number of cycles.
//   Keeps the previous sample, compares the absolute change against the
//   tolerance and runs a saturating counter of in-tolerance cycles.
//
// Ports
//   clk        in   1  system clock
//   rst_n      in   1  asynchronous active-low reset
//   i_amostra  in   W  raw gross weight sample, one per cycle
//   o_estavel  out  1  high while the counter sits at STABLE_CYC
// ---------------------------------------------------------------------------
module detector_estavel
    import balanca_pkg::*;
#(
    parameter int STABLE_CYC = STABLE_CYC_DEF,
    parameter int STABLE_TOL = STABLE_TOL_DEF
) (
    input  logic  clk,
    input  logic  rst_n,
    input  peso_t i_amostra,
    output logic  o_estavel
);

    localparam int CW = $clog2(STABLE_CYC + 1);

    localparam logic [CW-1:0] CONT_MAX = CW'(STABLE_CYC);
    localparam peso_t         TOL      = W'(STABLE_TOL);

    peso_t         r_anterior;
    logic [CW-1:0] r_cont;

    peso_t         w_delta;
    logic          w_dentro_tol;
    logic [CW-1:0] w_cont_next;

    assign w_delta      = dif_abs(i_amostra, r_anterior);
    assign w_dentro_tol = (w_delta <= TOL);

    // NOTE: every variable written in an always_comb gets a default value
    // first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_cont_next = '0;
        if (w_dentro_tol) begin
            w_cont_next = (r_cont == CONT_MAX) ? CONT_MAX : r_cont + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_anterior <= '0;
            r_cont     <= '0;
        end else begin
            r_anterior <= i_amostra;
            r_cont     <= w_cont_next;
        end
    end

    // Decoded straight from the counter register, so it changes only at edges.
    assign o_estavel = (r_cont == CONT_MAX);

endmodule : detector_estavel

// File: rtl/peso_sem_tara.sv
// ---------------------------------------------------------------------------
// peso_sem_tara
//   Net-weight stage of the digital scale. Subtracts the stored tare from the
//   raw gross sample and registers the net result for the display path.
//   Handles tare capture/clear and reports underflow, overload and stability.
//   Latency is one clock: outputs after edge k reflect the inputs at edge k.
//
// Ports
//   clk         in   1  system clock, rising edge
//   rst_n       in   1  asynchronous active-low reset
//   entrada     in   W  raw gross weight sample (unsigned)
//   tarar       in   1  tare capture request, level sampled each cycle
//   zerar       in   1  tare clear request, wins over tarar
//   resultado   out  W  net weight = entrada - tara, clamped at 0
//   tara_valor  out  W  tare currently stored
//   negativo    out  1  entrada was below the tare
//   sobrecarga  out  1  entrada above MAX_PESO
//   estavel     out  1  reading stable for STABLE_CYC cycles
// ---------------------------------------------------------------------------
module peso_sem_tara
    import balanca_pkg::*;
#(
    parameter peso_t MAX_PESO   = MAX_PESO_DEF,
    parameter int    STABLE_CYC = STABLE_CYC_DEF,
    parameter int    STABLE_TOL = STABLE_TOL_DEF
) (
    input  logic  clk,
    input  logic  rst_n,
    input  peso_t entrada,
    input  logic  tarar,
    input  logic  zerar,
    output peso_t resultado,
    output peso_t tara_valor,
    output logic  negativo,
    output logic  sobrecarga,
    output logic  estavel
);

    tara_op_t w_op;
    peso_t    w_tara_next;
    liquido_t w_liquido;

    peso_t    r_tara;
    peso_t    r_resultado;
    logic     r_negativo;
    logic     r_sobrecarga;

    // Clear has priority over capture.
    always_comb begin
        w_op = TARA_MANTER;
        if (zerar) begin
            w_op = TARA_ZERAR;
        end else if (tarar) begin
            w_op = TARA_CAPTURAR;
        end
    end

    always_comb begin
        w_tara_next = r_tara;
        unique case (w_op)
            TARA_ZERAR:    w_tara_next = '0;
            TARA_CAPTURAR: w_tara_next = entrada;
            default:       w_tara_next = r_tara;
        endcase
    end

    // The net value uses the tare as it will be after this edge, so a capture
    // shows zero and a clear shows the full gross weight in the same cycle.
    assign w_liquido = calc_liquido(entrada, w_tara_next);

    // NOTE: only a handful of flops here, no memory arrays, so every register
    // is reset; all outputs must read zero as soon as rst_n falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tara       <= '0;
            r_resultado  <= '0;
            r_negativo   <= 1'b0;
            r_sobrecarga <= 1'b0;
        end else begin
            r_tara       <= w_tara_next;
            r_resultado  <= w_liquido.valor;
            r_negativo   <= w_liquido.negativo;
            r_sobrecarga <= (entrada > MAX_PESO);
        end
    end

    // Stability looks at the raw gross sample only; tare activity is ignored.
    detector_estavel #(
        .STABLE_CYC (STABLE_CYC),
        .STABLE_TOL (STABLE_TOL)
    ) u_detector_estavel (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_amostra (entrada),
        .o_estavel (estavel)
    );

    assign resultado  = r_resultado;
    assign tara_valor = r_tara;
    assign negativo   = r_negativo;
    assign sobrecarga = r_sobrecarga;

endmodule : peso_sem_tara

// File: tb/tb_peso_sem_tara.sv
// ---------------------------------------------------------------------------
// tb_peso_sem_tara
//   Self-checking bench for peso_sem_tara: a directed vector table, hand
//   sequences for stability and asynchronous reset, and a randomized run
//   compared against a behavioural model of the scale.
// ---------------------------------------------------------------------------
module tb_peso_sem_tara;
    import balanca_pkg::*;

    logic  clk;
    logic  rst_n;
    peso_t entrada;
    logic  tarar;
    logic  zerar;
    peso_t resultado;
    peso_t tara_valor;
    logic  negativo;
    logic  sobrecarga;
    logic  estavel;

    int n_checks = 0;
    int n_errors = 0;

    peso_sem_tara dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .entrada    (entrada),
        .tarar      (tarar),
        .zerar      (zerar),
        .resultado  (resultado),
        .tara_valor (tara_valor),
        .negativo   (negativo),
        .sobrecarga (sobrecarga),
        .estavel    (estavel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model (plain integer arithmetic) --------
    int m_tara, m_prev, m_run;
    int m_res;
    bit m_neg, m_sob, m_est;

    function automatic void model_reset();
        m_tara = 0; m_prev = 0; m_run = 0;
        m_res = 0; m_neg = 0; m_sob = 0; m_est = 0;
    endfunction

    function automatic void model_step(input int e, input bit ta, input bit ze);
        int net, delta;
        if (ze)      m_tara = 0;
        else if (ta) m_tara = e;
        net   = e - m_tara;
        m_neg = (net < 0);
        m_res = m_neg ? 0 : net;
        m_sob = (e > 65520);
        delta = (e > m_prev) ? e - m_prev : m_prev - e;
        if (delta <= 2) m_run = (m_run >= 8) ? 8 : m_run + 1;
        else            m_run = 0;
        m_prev = e;
        m_est  = (m_run == 8);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs on the falling edge, let the rising edge
    // capture them, then advance the model.
    task automatic step(input peso_t e, input logic ta, input logic ze);
        @(negedge clk);
        entrada = e; tarar = ta; zerar = ze;
        @(posedge clk);
        #1;
        model_step(int'(e), ta, ze);
    endtask

    task automatic check_model(input string tag);
        check({tag, ".resultado"},  32'(resultado),  32'(m_res));
        check({tag, ".tara_valor"}, 32'(tara_valor), 32'(m_tara));
        check({tag, ".negativo"},   32'(negativo),   32'(m_neg));
        check({tag, ".sobrecarga"}, 32'(sobrecarga), 32'(m_sob));
        check({tag, ".estavel"},    32'(estavel),    32'(m_est));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; entrada = '0; tarar = 1'b0; zerar = 1'b0;
        #2;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- directed vector table -------------------------------
    typedef struct {
        peso_t e;
        logic  ta;
        logic  ze;
        peso_t exp_res;
        peso_t exp_tara;
        logic  exp_neg;
        logic  exp_sob;
    } vec_t;

    vec_t tabela[$];

    initial begin
        int last;
        int iv;
        rst_n = 1'b0; entrada = '0; tarar = 1'b0; zerar = 1'b0;
        model_reset();
        #1;
        check("reset.resultado",  32'(resultado),  32'd0);
        check("reset.tara_valor", 32'(tara_valor), 32'd0);
        check("reset.negativo",   32'(negativo),   32'd0);
        check("reset.sobrecarga", 32'(sobrecarga), 32'd0);
        check("reset.estavel",    32'(estavel),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        //                e        ta    ze    res      tara     neg   sob
        tabela.push_back('{16'd3,     1'b0, 1'b0, 16'd3,    16'd0,    1'b0, 1'b0});
        tabela.push_back('{16'd500,   1'b1, 1'b0, 16'd0,    16'd500,  1'b0, 1'b0});
        tabela.push_back('{16'd750,   1'b0, 1'b0, 16'd250,  16'd500,  1'b0, 1'b0});
        tabela.push_back('{16'd200,   1'b0, 1'b0, 16'd0,    16'd500,  1'b1, 1'b0});
        tabela.push_back('{16'd500,   1'b0, 1'b0, 16'd0,    16'd500,  1'b0, 1'b0});
        tabela.push_back('{16'd900,   1'b1, 1'b1, 16'd900,  16'd0,    1'b0, 1'b0});
        tabela.push_back('{16'hFFF1,  1'b0, 1'b0, 16'hFFF1, 16'd0,    1'b0, 1'b1});
        tabela.push_back('{16'hFFF0,  1'b0, 1'b0, 16'hFFF0, 16'd0,    1'b0, 1'b0});
        tabela.push_back('{16'd0,     1'b0, 1'b0, 16'd0,    16'd0,    1'b0, 1'b0});
        tabela.push_back('{16'hFFFF,  1'b0, 1'b0, 16'hFFFF, 16'd0,    1'b0, 1'b1});
        tabela.push_back('{16'd1234,  1'b1, 1'b0, 16'd0,    16'd1234, 1'b0, 1'b0});
        tabela.push_back('{16'd1234,  1'b0, 1'b0, 16'd0,    16'd1234, 1'b0, 1'b0});
        tabela.push_back('{16'd1235,  1'b0, 1'b0, 16'd1,    16'd1234, 1'b0, 1'b0});
        tabela.push_back('{16'd1233,  1'b0, 1'b0, 16'd0,    16'd1234, 1'b1, 1'b0});
        tabela.push_back('{16'd1233,  1'b0, 1'b1, 16'd1233, 16'd0,    1'b0, 1'b0});
        tabela.push_back('{16'd40,    1'b1, 1'b0, 16'd0,    16'd40,   1'b0, 1'b0});
        tabela.push_back('{16'd70,    1'b1, 1'b0, 16'd0,    16'd70,   1'b0, 1'b0});
        tabela.push_back('{16'd95,    1'b0, 1'b0, 16'd25,   16'd70,   1'b0, 1'b0});
        tabela.push_back('{16'hFFFF,  1'b1, 1'b0, 16'd0,    16'hFFFF, 1'b0, 1'b1});
        tabela.push_back('{16'hFFFE,  1'b0, 1'b0, 16'd0,    16'hFFFF, 1'b1, 1'b1});

        foreach (tabela[i]) begin
            step(tabela[i].e, tabela[i].ta, tabela[i].ze);
            check($sformatf("vec%0d.resultado", i),  32'(resultado),  32'(tabela[i].exp_res));
            check($sformatf("vec%0d.tara_valor", i), 32'(tara_valor), 32'(tabela[i].exp_tara));
            check($sformatf("vec%0d.negativo", i),   32'(negativo),   32'(tabela[i].exp_neg));
            check($sformatf("vec%0d.sobrecarga", i), 32'(sobrecarga), 32'(tabela[i].exp_sob));
            check($sformatf("vec%0d.estavel", i),    32'(estavel),    32'(m_est));
        end

        // ---------------- stability sequence --------------------------------
        // After reset the previous sample is 0, so the first 100 is a jump;
        // eight further in-tolerance samples bring estavel up on the ninth.
        do_reset();
        for (int i = 1; i <= 12; i++) begin
            step(16'd100, 1'b0, 1'b0);
            check($sformatf("estab%0d", i), 32'(estavel), (i >= 9) ? 32'd1 : 32'd0);
        end
        step(16'd110, 1'b0, 1'b0);
        check("estab.degrau", 32'(estavel), 32'd0);
        check("estab.degrau.res", 32'(resultado), 32'd110);

        // Drift within tolerance and tare activity keep the count going.
        for (int i = 1; i <= 10; i++) begin
            step(16'(110 + (i % 3)), (i == 4), (i == 7));
            check($sformatf("deriva%0d", i), 32'(estavel), (i >= 8) ? 32'd1 : 32'd0);
            check($sformatf("deriva%0d.model", i), 32'(resultado), 32'(m_res));
        end
        // Exactly the tolerance still counts, one more breaks it.
        step(16'(110 + 1 + 2), 1'b0, 1'b0);
        check("tol.limite", 32'(estavel), 32'd1);
        step(16'(113 + 3), 1'b0, 1'b0);
        check("tol.excedida", 32'(estavel), 32'd0);

        // ---------------- asynchronous reset mid-run -------------------------
        step(16'd800, 1'b1, 1'b0);
        step(16'd950, 1'b0, 1'b0);
        check("pre_rst.resultado", 32'(resultado), 32'd150);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async.resultado",  32'(resultado),  32'd0);
        check("async.tara_valor", 32'(tara_valor), 32'd0);
        check("async.negativo",   32'(negativo),   32'd0);
        check("async.sobrecarga", 32'(sobrecarga), 32'd0);
        check("async.estavel",    32'(estavel),    32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- randomized run vs model -----------------------------
        last = 0;
        for (int i = 0; i < 400; i++) begin
            logic ta, ze;
            int   sel;
            sel = int'($urandom_range(0, 99));
            if (sel < 70) begin
                iv = last + int'($urandom_range(0, 6)) - 3;
            end else if (sel < 80) begin
                iv = 65520 + int'($urandom_range(0, 15)) - 4;
            end else begin
                iv = int'($urandom_range(0, 65535));
            end
            if (iv < 0)     iv = 0;
            if (iv > 65535) iv = 65535;
            last = iv;
            ta = ($urandom_range(0, 99) < 10);
            ze = ($urandom_range(0, 99) < 5);
            step(16'(iv), ta, ze);
            check_model($sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_peso_sem_tara
